// File: rtl/rob.sv
// Reorder buffer: 32-entry circular buffer tracking in-flight instructions.
// Retires in order, frees the old physical register of each retired
// destination, and requests a free-list head restore on a mispredicted branch.
// Optional debug ports (cnt_o/hd_o/tl_o) are built when ROB_DEBUG_EN is defined.
module rob (
  input  logic       clk,
  input  logic       rst,
  input  logic       dispatch_en_i,
  input  logic       dispatch_has_dest_i,
  input  logic       dispatch_is_br_i,
  input  logic [5:0] dispatch_old_preg_i,
  input  logic [4:0] dispatch_fl_head_i,
  input  logic       cdb_en_i,
  input  logic [4:0] cdb_rob_idx_i,
  input  logic       cdb_br_mispred_i,
  output logic       rob_full_o,
  output logic [4:0] rob_tail_o,
  output logic       retire_en_o,
  output logic [5:0] retire_preg_o,
  output logic       recover_en_o,
  output logic [4:0] recover_head_o
`ifdef ROB_DEBUG_EN
  ,
  output logic [5:0] cnt_o,
  output logic [4:0] hd_o,
  output logic [4:0] tl_o
`endif
);

  localparam int DEPTH = 32;

  // Per-entry status bits (reset / flushed as a whole)
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] mispred_q, mispred_d;

  // Per-entry payload, only meaningful while the entry is valid
  logic [DEPTH-1:0] has_dest_q;
  logic [DEPTH-1:0] is_br_q;
  logic [5:0]       old_preg_q [DEPTH];
  logic [4:0]       fl_head_q  [DEPTH];

  logic [4:0] head_q, head_d;
  logic [4:0] tail_q, tail_d;
  logic [5:0] count_q, count_d;

  logic full;
  logic head_rdy;
  logic head_mis;
  logic recover;
  logic retire_norm;
  logic dispatch_acc;

  // Head-entry decode, retire/recover decisions and dispatch acceptance
  always_comb begin
    full         = (count_q == 6'd32);
    head_rdy     = valid_q[head_q] && done_q[head_q];
    head_mis     = mispred_q[head_q] && is_br_q[head_q];
    recover      = rst && head_rdy && head_mis;
    retire_norm  = rst && head_rdy && !head_mis;
    // Full is judged on the current count, so a retire this cycle does not
    // open a slot for a dispatch in the same cycle.
    dispatch_acc = dispatch_en_i && !full && !recover;
  end

  // Externally visible outputs; all forced to zero while reset is held
  always_comb begin
    rob_full_o     = rst && full;
    rob_tail_o     = rst ? tail_q : 5'd0;
    retire_en_o    = retire_norm && has_dest_q[head_q];
    retire_preg_o  = retire_en_o ? old_preg_q[head_q] : 6'd0;
    recover_en_o   = recover;
    recover_head_o = recover ? fl_head_q[head_q] : 5'd0;
  end

`ifdef ROB_DEBUG_EN
  // Debug view of occupancy and pointers
  always_comb begin
    cnt_o = rst ? count_q : 6'd0;
    hd_o  = rst ? head_q  : 5'd0;
    tl_o  = rst ? tail_q  : 5'd0;
  end
`endif

  // Pointer and occupancy next-state; a recovery flushes everything
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (recover) begin
      head_d  = 5'd0;
      tail_d  = 5'd0;
      count_d = 6'd0;
    end else begin
      if (dispatch_acc) tail_d = tail_q + 5'd1;
      if (retire_norm)  head_d = head_q + 5'd1;
      case ({dispatch_acc, retire_norm})
        2'b10:   count_d = count_q + 6'd1;
        2'b01:   count_d = count_q - 6'd1;
        default: count_d = count_q;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr;
      logic rt;
      logic cd;
      // Status next-state for one entry: dispatch, completion, retire, flush
      always_comb begin
        wr = dispatch_acc && (tail_q == 5'(gi));
        rt = retire_norm && (head_q == 5'(gi));
        // Completions to entries that are not in flight are dropped
        cd = cdb_en_i && valid_q[gi] && (cdb_rob_idx_i == 5'(gi));
        valid_d[gi]   = valid_q[gi];
        done_d[gi]    = done_q[gi];
        mispred_d[gi] = mispred_q[gi];
        if (recover) begin
          valid_d[gi]   = 1'b0;
          done_d[gi]    = 1'b0;
          mispred_d[gi] = 1'b0;
        end else if (wr) begin
          valid_d[gi]   = 1'b1;
          done_d[gi]    = 1'b0;
          mispred_d[gi] = 1'b0;
        end else begin
          if (rt) valid_d[gi] = 1'b0;
          if (cd) begin
            done_d[gi]    = 1'b1;
            mispred_d[gi] = cdb_br_mispred_i;
          end
        end
      end
    end
  endgenerate

  // Payload capture at the tail on an accepted dispatch
  always_ff @(posedge clk) begin
    if (dispatch_acc) begin
      has_dest_q[tail_q] <= dispatch_has_dest_i;
      is_br_q[tail_q]    <= dispatch_is_br_i;
      old_preg_q[tail_q] <= dispatch_old_preg_i;
      fl_head_q[tail_q]  <= dispatch_fl_head_i;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      head_q    <= 5'd0;
      tail_q    <= 5'd0;
      count_q   <= 6'd0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer: expected retire/recover events are
// queued as stimulus is issued and checked by an independent monitor.
module tb_rob;
  logic       clk;
  logic       rst;
  logic       dispatch_en_i;
  logic       dispatch_has_dest_i;
  logic       dispatch_is_br_i;
  logic [5:0] dispatch_old_preg_i;
  logic [4:0] dispatch_fl_head_i;
  logic       cdb_en_i;
  logic [4:0] cdb_rob_idx_i;
  logic       cdb_br_mispred_i;
  logic       rob_full_o;
  logic [4:0] rob_tail_o;
  logic       retire_en_o;
  logic [5:0] retire_preg_o;
  logic       recover_en_o;
  logic [4:0] recover_head_o;
`ifdef ROB_DEBUG_EN
  logic [5:0] cnt_o;
  logic [4:0] hd_o;
  logic [4:0] tl_o;
`endif

  int checks = 0;
  int errors = 0;
  // {is_recover, value}
  logic [6:0] exp_q [$];

  rob dut (
    .clk                 (clk),
    .rst                 (rst),
    .dispatch_en_i       (dispatch_en_i),
    .dispatch_has_dest_i (dispatch_has_dest_i),
    .dispatch_is_br_i    (dispatch_is_br_i),
    .dispatch_old_preg_i (dispatch_old_preg_i),
    .dispatch_fl_head_i  (dispatch_fl_head_i),
    .cdb_en_i            (cdb_en_i),
    .cdb_rob_idx_i       (cdb_rob_idx_i),
    .cdb_br_mispred_i    (cdb_br_mispred_i),
    .rob_full_o          (rob_full_o),
    .rob_tail_o          (rob_tail_o),
    .retire_en_o         (retire_en_o),
    .retire_preg_o       (retire_preg_o),
    .recover_en_o        (recover_en_o),
    .recover_head_o      (recover_head_o)
`ifdef ROB_DEBUG_EN
    ,
    .cnt_o               (cnt_o),
    .hd_o                (hd_o),
    .tl_o                (tl_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dbg(input string name, input int cnt, input int hd, input int tl);
`ifdef ROB_DEBUG_EN
    chk({name, "_cnt"}, int'(cnt_o), cnt);
    chk({name, "_hd"},  int'(hd_o),  hd);
    chk({name, "_tl"},  int'(tl_o),  tl);
`else
    if (cnt < 0 || hd < 0 || tl < 0) $display("note %s bad args", name);
`endif
  endtask

  task automatic set_dispatch(input logic en, input logic hd, input logic br,
                              input logic [5:0] preg, input logic [4:0] flh);
    dispatch_en_i       = en;
    dispatch_has_dest_i = hd;
    dispatch_is_br_i    = br;
    dispatch_old_preg_i = preg;
    dispatch_fl_head_i  = flh;
  endtask

  task automatic set_cdb(input logic en, input logic [4:0] idx, input logic mis);
    cdb_en_i         = en;
    cdb_rob_idx_i    = idx;
    cdb_br_mispred_i = mis;
  endtask

  // Monitor: every retire or recover the DUT presents must match the queue head
  always @(negedge clk) begin
    logic [6:0] act;
    logic [6:0] exp;
    if (rst && (retire_en_o || recover_en_o)) begin
      act = recover_en_o ? {1'b1, 1'b0, recover_head_o} : {1'b0, retire_preg_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%h expected=none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act != exp) begin
          errors++;
          $display("FAIL sb_event actual=%h expected=%h", act, exp);
        end else begin
          $display("ok   sb_event %h", act);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_dispatch(1'b0, 1'b0, 1'b0, 6'd0, 5'd0);
    set_cdb(1'b0, 5'd0, 1'b0);
    tick();
    tick();
    // Reset state
    chk("rst_full", int'(rob_full_o), 0);
    chk("rst_tail", int'(rob_tail_o), 0);
    chk("rst_ret_en", int'(retire_en_o), 0);
    chk("rst_ret_preg", int'(retire_preg_o), 0);
    chk("rst_rec_en", int'(recover_en_o), 0);
    chk("rst_rec_head", int'(recover_head_o), 0);
    chk_dbg("rst", 0, 0, 0);
    rst = 1'b1;

    // Fill all 32 entries, old_preg = index
    for (int i = 0; i < 32; i++) begin
      set_dispatch(1'b1, 1'b1, 1'b0, 6'(i), 5'd0);
      if (i == 0 || i == 31) chk("fill_alloc_idx", int'(rob_tail_o), i);
      tick();
      chk("fill_tail", int'(rob_tail_o), (i + 1) % 32);
      chk_dbg("fill", i + 1, 0, (i + 1) % 32);
    end
    chk("fill_full", int'(rob_full_o), 1);
    // 33rd dispatch is dropped
    set_dispatch(1'b1, 1'b1, 1'b0, 6'd40, 5'd0);
    tick();
    chk("over_tail", int'(rob_tail_o), 0);
    chk("over_full", int'(rob_full_o), 1);
    chk("over_no_retire", int'(retire_en_o), 0);
    set_dispatch(1'b0, 1'b0, 1'b0, 6'd0, 5'd0);

    // Complete 0..31 in order: one retire per cycle, pregs 0..31
    for (int k = 0; k < 32; k++) begin
      set_cdb(1'b1, 5'(k), 1'b0);
      exp_q.push_back({1'b0, 6'(k)});
      tick();
      chk("drain_ret_en", int'(retire_en_o), 1);
      chk("drain_ret_preg", int'(retire_preg_o), k);
    end
    set_cdb(1'b0, 5'd0, 1'b0);
    tick();
    chk("drain_done_ret", int'(retire_en_o), 0);
    chk("drain_done_tail", int'(rob_tail_o), 0);
    chk("drain_done_full", int'(rob_full_o), 0);
    chk_dbg("drain_done", 0, 0, 0);

    // Out-of-order completion, then a mispredicted branch at idx 2
    set_dispatch(1'b1, 1'b1, 1'b0, 6'd10, 5'd0); tick();
    set_dispatch(1'b1, 1'b1, 1'b0, 6'd11, 5'd0); tick();
    set_dispatch(1'b1, 1'b0, 1'b1, 6'd33, 5'd7); tick();
    set_dispatch(1'b1, 1'b1, 1'b0, 6'd20, 5'd3); tick();
    set_dispatch(1'b0, 1'b0, 1'b0, 6'd0, 5'd0);
    chk("ooo_tail", int'(rob_tail_o), 4);
    set_cdb(1'b1, 5'd1, 1'b0);
    tick();
    set_cdb(1'b0, 5'd0, 1'b0);
    chk("ooo_stall0", int'(retire_en_o), 0);
    tick();
    chk("ooo_stall1", int'(retire_en_o), 0);
    exp_q.push_back({1'b0, 6'd10});
    exp_q.push_back({1'b0, 6'd11});
    set_cdb(1'b1, 5'd0, 1'b0);
    tick();
    set_cdb(1'b0, 5'd0, 1'b0);
    chk("ooo_ret0_en", int'(retire_en_o), 1);
    chk("ooo_ret0_preg", int'(retire_preg_o), 10);
    tick();
    chk("ooo_ret1_en", int'(retire_en_o), 1);
    chk("ooo_ret1_preg", int'(retire_preg_o), 11);
    tick();
    chk("br_wait_ret", int'(retire_en_o), 0);
    chk("br_wait_rec", int'(recover_en_o), 0);
    exp_q.push_back({1'b1, 6'd7});
    set_cdb(1'b1, 5'd2, 1'b1);
    tick();
    set_cdb(1'b0, 5'd0, 1'b0);
    chk("rec_en", int'(recover_en_o), 1);
    chk("rec_head", int'(recover_head_o), 7);
    chk("rec_ret_en", int'(retire_en_o), 0);
    tick();
    chk("rec_after_en", int'(recover_en_o), 0);
    chk("rec_after_head", int'(recover_head_o), 0);
    chk("rec_after_tail", int'(rob_tail_o), 0);
    chk("rec_after_ret", int'(retire_en_o), 0);
    chk_dbg("rec_after", 0, 0, 0);

    // Mid-stream reset with 10 entries; a stale completion must not retire
    for (int i = 0; i < 10; i++) begin
      set_dispatch(1'b1, 1'b1, 1'b0, 6'(i + 1), 5'd0);
      tick();
    end
    chk("pre_rst_tail", int'(rob_tail_o), 10);
    chk_dbg("pre_rst", 10, 0, 10);
    rst = 1'b0;
    set_cdb(1'b1, 5'd0, 1'b0);
    tick();
    chk("mid_rst_tail", int'(rob_tail_o), 0);
    chk("mid_rst_ret", int'(retire_en_o), 0);
    chk("mid_rst_preg", int'(retire_preg_o), 0);
    rst = 1'b1;
    set_dispatch(1'b0, 1'b0, 1'b0, 6'd0, 5'd0);
    set_cdb(1'b1, 5'd3, 1'b0);
    tick();
    set_cdb(1'b0, 5'd0, 1'b0);
    chk("stale_ret", int'(retire_en_o), 0);
    chk("stale_full", int'(rob_full_o), 0);
    chk("stale_tail", int'(rob_tail_o), 0);
    chk_dbg("stale", 0, 0, 0);
    tick();
    chk("stale_ret2", int'(retire_en_o), 0);

    // Full ROB with done head: retire wins, dispatch waits one cycle
    for (int i = 0; i < 32; i++) begin
      set_dispatch(1'b1, 1'b1, 1'b0, 6'(i + 30), 5'd0);
      tick();
    end
    set_dispatch(1'b0, 1'b0, 1'b0, 6'd0, 5'd0);
    chk("refill_full", int'(rob_full_o), 1);
    exp_q.push_back({1'b0, 6'd30});
    set_cdb(1'b1, 5'd0, 1'b0);
    tick();
    set_cdb(1'b0, 5'd0, 1'b0);
    set_dispatch(1'b1, 1'b1, 1'b0, 6'd63, 5'd0);
    chk("both_full", int'(rob_full_o), 1);
    chk("both_ret_en", int'(retire_en_o), 1);
    chk("both_ret_preg", int'(retire_preg_o), 30);
    tick();
    chk("both_after_full", int'(rob_full_o), 0);
    chk("both_after_tail", int'(rob_tail_o), 0);
    chk_dbg("both_after", 31, 1, 0);
    tick();
    set_dispatch(1'b0, 1'b0, 1'b0, 6'd0, 5'd0);
    chk("both_next_tail", int'(rob_tail_o), 1);
    chk("both_next_full", int'(rob_full_o), 1);
    chk("both_next_ret", int'(retire_en_o), 0);
    chk_dbg("both_next", 32, 1, 1);
    tick();
    tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
